// File: rtl/dms_pfd_sync_if.sv
// Signal bundle between a phase-frequency detector and its driver.
// The master side owns the data level and both clocks; the slave side owns the pump requests.
interface dms_pfd_sync_if;
    logic d;
    logic refclk;
    logic finalclk;
    logic up;
    logic down;

    modport master (
        output d,
        output refclk,
        output finalclk,
        input  up,
        input  down
    );

    modport slave (
        input  d,
        input  refclk,
        input  finalclk,
        output up,
        output down
    );
endinterface

// File: rtl/dms_pfd_sync.sv
// Sampled phase-frequency detector: refclk and finalclk are synchronized into clk,
// edge-detected, and steer a four-state up/down machine with a timed BOTH reset phase.
module dms_pfd_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_DLY     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dms_pfd_sync_if.slave  pfd
);

    // Bit 0 drives up and bit 1 drives down, so the outputs come straight from flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DN   = 2'b10,
        BOTH = 2'b11
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RST_DLY - 1);

    logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic [SYNC_STAGES-1:0] fb_sync_q, fb_sync_d;
    logic                   ref_hist_q, fb_hist_q;
    logic                   ref_rise, fb_rise;
    state_t                 state_q;
    logic [3:0]             cnt_q;

    assign ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], pfd.refclk};
    assign fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0], pfd.finalclk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_hist_q <= 1'b0;
            fb_hist_q  <= 1'b0;
        end else begin
            ref_sync_q <= ref_sync_d;
            fb_sync_q  <= fb_sync_d;
            ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
            fb_hist_q  <= fb_sync_q[SYNC_STAGES-1];
        end
    end

    assign ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
    assign fb_rise  = fb_sync_q[SYNC_STAGES-1] & ~fb_hist_q;

    // d only gates the launch out of IDLE; once pumping, only the opposite edge matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pfd.d && ref_rise && fb_rise) begin
                        state_q <= BOTH;
                        cnt_q   <= CNT_LOAD;
                    end else if (pfd.d && ref_rise) begin
                        state_q <= UP;
                    end else if (pfd.d && fb_rise) begin
                        state_q <= DN;
                    end
                end
                UP: begin
                    if (fb_rise) begin
                        state_q <= BOTH;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                DN: begin
                    if (ref_rise) begin
                        state_q <= BOTH;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BOTH: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign pfd.up   = state_q[0];
    assign pfd.down = state_q[1];

endmodule

// File: tb/tb_dms_pfd_sync.sv
// Bench for dms_pfd_sync: directed scenarios plus random clock streams, each checked
// cycle by cycle against an edge-event reference model of the detector.
module tb_dms_pfd_sync;

    localparam int SYNC_STAGES = 2;
    localparam int RST_DLY     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dms_pfd_sync_if bus ();

    dms_pfd_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_DLY     (RST_DLY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pfd   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the last SYNC_STAGES+1 input samples per clock, plus pump flags and BOTH time left.
    bit ref_hist[$];
    bit fb_hist[$];
    bit m_up, m_dn;
    int m_left;

    task automatic model_reset();
        ref_hist = {};
        fb_hist  = {};
        for (int i = 0; i <= SYNC_STAGES; i++) begin
            ref_hist.push_back(1'b0);
            fb_hist.push_back(1'b0);
        end
        m_up   = 1'b0;
        m_dn   = 1'b0;
        m_left = 0;
    endtask

    task automatic model_edge(input bit r, input bit f, input bit dd);
        bit rr, fr;
        rr = ref_hist[1] & ~ref_hist[0];
        fr = fb_hist[1] & ~fb_hist[0];
        if (m_up && m_dn) begin
            m_left--;
            if (m_left == 0) begin
                m_up = 1'b0;
                m_dn = 1'b0;
            end
        end else if (m_up) begin
            if (fr) begin m_dn = 1'b1; m_left = RST_DLY; end
        end else if (m_dn) begin
            if (rr) begin m_up = 1'b1; m_left = RST_DLY; end
        end else if (dd) begin
            if (rr) m_up = 1'b1;
            if (fr) m_dn = 1'b1;
            if (rr && fr) m_left = RST_DLY;
        end
        ref_hist.push_back(r);
        fb_hist.push_back(f);
        void'(ref_hist.pop_front());
        void'(fb_hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(bus.refclk, bus.finalclk, bus.d);
        #1;
    endtask

    task automatic settle();
        bus.refclk   = 1'b0;
        bus.finalclk = 1'b0;
        for (int i = 0; i < SYNC_STAGES + RST_DLY + 3; i++) step();
    endtask

    task automatic test_reset();
        bus.d = 1'b0; bus.refclk = 1'b0; bus.finalclk = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.up, bus.down} !== 2'b00)
            $display("FAIL reset_state: up/down=%b%b expected 00", bus.up, bus.down);
        else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) step();
        n_checks++;
        if ({bus.up, bus.down} !== 2'b00)
            $display("FAIL reset_idle: up/down=%b%b expected 00", bus.up, bus.down);
        else n_pass++;
    endtask

    task automatic test_ref_leads();
        int n_up = 0, n_both = 0, bad = 0;
        bus.d = 1'b1; bus.refclk = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) bus.finalclk = 1'b1;
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up && !bus.down) n_up++;
            if (bus.up && bus.down) n_both++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL ref_leads_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (n_up != 10) $display("FAIL ref_leads_up_width: got %0d expected 10", n_up);
        else n_pass++;
        n_checks++;
        if (n_both != RST_DLY) $display("FAIL ref_leads_both_width: got %0d expected %0d", n_both, RST_DLY);
        else n_pass++;
        n_checks++;
        if ({bus.up, bus.down} !== 2'b00) $display("FAIL ref_leads_end: up/down=%b%b expected 00", bus.up, bus.down);
        else n_pass++;
        settle();
    endtask

    task automatic test_fb_leads();
        int n_dn = 0, n_both = 0, bad = 0;
        bus.d = 1'b1; bus.finalclk = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c == 6) bus.refclk = 1'b1;
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (!bus.up && bus.down) n_dn++;
            if (bus.up && bus.down) n_both++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL fb_leads_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (n_dn != 6) $display("FAIL fb_leads_down_width: got %0d expected 6", n_dn);
        else n_pass++;
        n_checks++;
        if (n_both != RST_DLY) $display("FAIL fb_leads_both_width: got %0d expected %0d", n_both, RST_DLY);
        else n_pass++;
        settle();
    endtask

    task automatic test_simultaneous();
        int n_single = 0, n_both = 0, bad = 0;
        bus.d = 1'b1; bus.refclk = 1'b1; bus.finalclk = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up ^ bus.down) n_single++;
            if (bus.up && bus.down) n_both++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL simul_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (n_single != 0) $display("FAIL simul_single_side: got %0d cycles expected 0", n_single);
        else n_pass++;
        n_checks++;
        if (n_both != RST_DLY) $display("FAIL simul_both_width: got %0d expected %0d", n_both, RST_DLY);
        else n_pass++;
        settle();
    endtask

    task automatic test_d_hold();
        int n_up = 0, n_both = 0, bad = 0;
        bus.d = 1'b1; bus.refclk = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c == 3) bus.d = 1'b0;
            if (c == 8) bus.finalclk = 1'b1;
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up && !bus.down) n_up++;
            if (bus.up && bus.down) n_both++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL d_hold_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (n_up != 8) $display("FAIL d_hold_up_width: got %0d expected 8", n_up);
        else n_pass++;
        n_checks++;
        if (n_both != RST_DLY) $display("FAIL d_hold_both_width: got %0d expected %0d", n_both, RST_DLY);
        else n_pass++;
        bus.d = 1'b1;
        settle();
    endtask

    task automatic test_second_ref();
        int n_up = 0, runs = 0, bad = 0;
        bit prev_up = 1'b0;
        bus.d = 1'b1; bus.refclk = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) bus.refclk = 1'b0;
            if (c == 6) bus.refclk = 1'b1;
            if (c == 12) bus.finalclk = 1'b1;
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up && !bus.down) n_up++;
            if (bus.up && !prev_up) runs++;
            prev_up = bus.up;
        end
        n_checks++;
        if (bad != 0) $display("FAIL second_ref_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (n_up != 12) $display("FAIL second_ref_up_width: got %0d expected 12", n_up);
        else n_pass++;
        n_checks++;
        if (runs != 1) $display("FAIL second_ref_up_runs: got %0d expected 1", runs);
        else n_pass++;
        settle();
    endtask

    task automatic test_d_low();
        int active = 0, bad = 0;
        bus.d = 1'b0;
        for (int c = 0; c < 120; c++) begin
            bus.refclk   = ((c % 6) < 3);
            bus.finalclk = (((c + 2) % 7) < 3);
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up || bus.down) active++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL d_low_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (active != 0) $display("FAIL d_low_outputs: %0d active cycles expected 0", active);
        else n_pass++;
        bus.d = 1'b1;
        settle();
    endtask

    task automatic test_freq_error();
        int widths[$];
        int cur = 0, br = 0, max_br = 0, bad = 0;
        bus.d = 1'b1;
        for (int t = 0; t < 200; t++) begin
            bus.refclk   = ((t % 20) < 10);
            bus.finalclk = (t >= 2) && (((t - 2) % 22) < 11);
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) bad++;
            if (bus.up && !bus.down) cur++;
            else if (cur != 0) begin widths.push_back(cur); cur = 0; end
            if (bus.up && bus.down) br++; else br = 0;
            if (br > max_br) max_br = br;
        end
        n_checks++;
        if (bad != 0) $display("FAIL freq_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (widths.size() != 9) $display("FAIL freq_pulse_count: got %0d expected 9", widths.size());
        else n_pass++;
        for (int i = 1; i < widths.size(); i++) begin
            n_checks++;
            if (widths[i] <= widths[i-1])
                $display("FAIL freq_width_grows: pulse %0d width %0d not above %0d", i, widths[i], widths[i-1]);
            else n_pass++;
        end
        n_checks++;
        if (max_br > RST_DLY) $display("FAIL freq_both_max: got %0d expected <= %0d", max_br, RST_DLY);
        else n_pass++;
        settle();
    endtask

    task automatic test_random();
        int rh = 0, fh = 0, br = 0, max_br = 0, bad = 0;
        bus.d = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (rh == 0) begin bus.refclk = ~bus.refclk; rh = $urandom_range(1, 8); end
            if (fh == 0) begin bus.finalclk = ~bus.finalclk; fh = $urandom_range(1, 8); end
            rh--; fh--;
            if ($urandom_range(0, 15) == 0) bus.d = ~bus.d;
            step();
            if ({bus.up, bus.down} !== {m_up, m_dn}) begin
                bad++;
                if (bad <= 3) $display("FAIL random_cycle_%0d: up/down=%b%b expected %b%b", c, bus.up, bus.down, m_up, m_dn);
            end
            if (bus.up && bus.down) br++; else br = 0;
            if (br > max_br) max_br = br;
        end
        n_checks++;
        if (bad != 0) $display("FAIL random_model: %0d cycles differ, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (max_br > RST_DLY) $display("FAIL random_both_max: got %0d expected <= %0d", max_br, RST_DLY);
        else n_pass++;
        bus.d = 1'b1;
        settle();
    endtask

    task automatic test_reset_mid_both();
        int guard = 0, active = 0;
        bus.d = 1'b1; bus.refclk = 1'b1; bus.finalclk = 1'b1;
        while (!(m_up && m_dn) && guard < 10) begin step(); guard++; end
        n_checks++;
        if ({bus.up, bus.down} !== 2'b11) $display("FAIL mid_both_entry: up/down=%b%b expected 11", bus.up, bus.down);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.up, bus.down} !== 2'b00) $display("FAIL mid_both_async_reset: up/down=%b%b expected 00", bus.up, bus.down);
        else n_pass++;
        step();
        step();
        bus.refclk = 1'b0; bus.finalclk = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.up || bus.down) active++;
        end
        n_checks++;
        if (active != 0) $display("FAIL post_reset_quiet: %0d active cycles expected 0", active);
        else n_pass++;
    endtask

    task automatic test_release_high();
        bit up_early, up_on_time;
        rst_n = 1'b0;
        step();
        bus.d = 1'b1; bus.refclk = 1'b1; bus.finalclk = 1'b0;
        rst_n = 1'b1;
        up_early = 1'b0; up_on_time = 1'b0;
        for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
            step();
            if (i == SYNC_STAGES) up_early = bus.up;
            if (i == SYNC_STAGES + 1) up_on_time = bus.up;
        end
        n_checks++;
        if (up_early !== 1'b0) $display("FAIL release_high_early: up=%b expected 0", up_early);
        else n_pass++;
        n_checks++;
        if (up_on_time !== 1'b1) $display("FAIL release_high_latency: up=%b expected 1", up_on_time);
        else n_pass++;
        bus.finalclk = 1'b1;
        for (int c = 0; c < 10; c++) step();
        n_checks++;
        if ({bus.up, bus.down} !== {m_up, m_dn} || {bus.up, bus.down} !== 2'b00)
            $display("FAIL release_high_return: up/down=%b%b expected 00", bus.up, bus.down);
        else n_pass++;
        settle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ref_leads();
        test_fb_leads();
        test_simultaneous();
        test_d_hold();
        test_second_ref();
        test_d_low();
        test_freq_error();
        test_random();
        test_reset_mid_both();
        test_release_high();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
